mi32_slave_regs: RTL
====================

MI32_SLAVE_REGS -- requirements
Module: mi32_slave_regs

Interface
REQ-001 SHALL have parameter REG_COUNT, default 16, meaning the number of 32-bit registers (power of two, 4..256).
REQ-002 SHALL have parameter READ_LATENCY, default 2, meaning the cycles from read acceptance to DRDY (1..4).
REQ-003 SHALL have parameter ID_VALUE, default 32'h4D493332, meaning the read-only content of register 0.
REQ-004 SHALL have port CLK, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 SHALL have port RESET_N, input, 1 bit: reset, asynchronous and active-low.
REQ-006 SHALL have port DWR, input, 32 bits: write data.
REQ-007 SHALL have port ADDR, input, 32 bits: byte address.
REQ-008 SHALL have port BE, input, 4 bits: byte enables for writes.
REQ-009 SHALL have port RD, input, 1 bit: read request.
REQ-010 SHALL have port WR, input, 1 bit: write request.
REQ-011 SHALL have port ARDY, output, 1 bit: the request is accepted in this cycle.
REQ-012 SHALL have port DRD, output, 32 bits: read data.
REQ-013 SHALL have port DRDY, output, 1 bit: DRD is valid.
REQ-014 SHALL have port ERR_CNT, output, 16 bits: out-of-range access count.

Function
REQ-015 SHALL implement a two-state FSM with states INIT and RUN.
REQ-016 In INIT, a counter SHALL clear one register per cycle, from index 1 to REG_COUNT-1, then enter RUN; INIT therefore lasts REG_COUNT-1 cycles.
REQ-017 ARDY SHALL be 0 in INIT and (RD or WR) in RUN; a request is accepted only when ARDY=1 at a clock edge.
REQ-018 Word index SHALL be ADDR[log2(REG_COUNT)+1:2]; ADDR[1:0] are ignored; any set bit in ADDR[31:log2(REG_COUNT)+2] marks the access out-of-range.
REQ-019 An accepted write SHALL update each byte lane i where BE[i]=1; lanes with BE[i]=0 are unchanged.
REQ-020 Writes to register 0 and out-of-range writes SHALL be ignored.
REQ-021 An accepted read SHALL assert DRDY for exactly one cycle, exactly READ_LATENCY cycles after acceptance.
REQ-022 Read data SHALL be sampled at acceptance: register 0 returns ID_VALUE, out-of-range returns 32'h00000000.
REQ-023 Reads SHALL be fully pipelined: back-to-back accepted reads produce back-to-back DRDY pulses in request order.
REQ-024 A read accepted in the cycle after a write to the same register SHALL return the written value.
REQ-025 If RD=1 and WR=1 together, the write SHALL be performed, the read discarded, and no DRDY generated.
REQ-026 DRD SHALL hold its last value when DRDY=0.

Reset
REQ-027 RESET_N=0 SHALL immediately force ARDY=0, DRDY=0, DRD=0, ERR_CNT=0, FSM=INIT and the init counter=1, and discard pending reads.
REQ-028 Register contents after reset SHALL be cleared by the INIT sweep, not by the reset itself.
REQ-029 Reset asserted mid-INIT or with reads in flight SHALL restart INIT from index 1 after release, with no DRDY for the discarded reads.

Configuration
REQ-030 With macro MI32_SLAVE_ERRCNT_EN defined, each accepted out-of-range read or write SHALL increment ERR_CNT, saturating at 16'hFFFF.
REQ-031 Without MI32_SLAVE_ERRCNT_EN, ERR_CNT SHALL be constant 0 and no counter logic SHALL be present.

Verification
REQ-032 Release reset, hold RD=1 -> ARDY=0 for 15 cycles (REG_COUNT=16), then 1; the read of ADDR 0x0 returns 0x4D493332 two cycles after acceptance.
REQ-033 Write 0xAABBCCDD to ADDR 0x4 with BE=4'b0101, then read ADDR 0x4 -> DRD=0x00BB00DD.
REQ-034 Issue reads of ADDR 0x4, 0x8 and 0xC on consecutive cycles -> three consecutive DRDY cycles returning data in that order.
REQ-035 Drive RD=WR=1 to ADDR 0x8 with DWR=0x12345678 -> no DRDY; a later read of 0x8 returns 0x12345678.
REQ-036 With MI32_SLAVE_ERRCNT_EN, read ADDR 0x100 -> DRD=0, ERR_CNT=1; write ADDR 0x0 -> register 0 still reads ID_VALUE.
REQ-037 Assert RESET_N=0 with two reads in flight -> DRDY stays 0, FSM re-runs INIT, and all registers 1..15 read 0.

Source files
------------

// File: rtl/mi32_slave_regs.sv
// MI32 register-file slave: ID register 0, INIT clear sweep, pipelined reads.
// Define MI32_SLAVE_ERRCNT_EN to count out-of-range accesses on ERR_CNT.
module mi32_slave_regs #(
  parameter int          REG_COUNT    = 16,
  parameter int          READ_LATENCY = 2,
  parameter logic [31:0] ID_VALUE     = 32'h4D493332
) (
  input  logic        CLK,
  input  logic        RESET_N,
  input  logic [31:0] DWR,
  input  logic [31:0] ADDR,
  input  logic [3:0]  BE,
  input  logic        RD,
  input  logic        WR,
  output logic        ARDY,
  output logic [31:0] DRD,
  output logic        DRDY,
  output logic [15:0] ERR_CNT
);

  localparam int AW = $clog2(REG_COUNT);

  typedef enum logic {INIT, RUN} state_t;

  state_t          state;
  state_t          state_n;
  logic [AW-1:0]   init_cnt;
  logic [AW-1:0]   init_cnt_n;
  logic [31:0]     regs [REG_COUNT];
  logic [AW-1:0]   idx;
  logic            oor;
  logic            wr_acc;
  logic            rd_acc;
  logic [31:0]     rdata;
  logic            unused_addr;

  assign idx         = ADDR[AW+1:2];
  assign oor         = |ADDR[31:AW+2];
  assign unused_addr = ^ADDR[1:0];

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state    <= INIT;
      init_cnt <= AW'(1);
    end else begin
      state    <= state_n;
      init_cnt <= init_cnt_n;
    end
  end

  always_comb begin
    state_n    = state;
    init_cnt_n = init_cnt;
    unique case (state)
      INIT: begin
        init_cnt_n = init_cnt + AW'(1);
        if (init_cnt == AW'(REG_COUNT - 1)) begin
          state_n    = RUN;
          init_cnt_n = AW'(1);
        end
      end
      RUN: begin
        state_n = RUN;
      end
    endcase
  end

  assign ARDY   = (state == RUN) && (RD || WR);
  assign wr_acc = ARDY && WR && !oor && (idx != '0);
  // A simultaneous write wins; the read is dropped entirely.
  assign rd_acc = ARDY && RD && !WR;

  // Storage is never reset: the INIT sweep is what clears it.
  always_ff @(posedge CLK) begin
    if (state == INIT) begin
      regs[init_cnt] <= '0;
    end else if (wr_acc) begin
      for (int b = 0; b < 4; b++) begin
        if (BE[b]) regs[idx][8*b +: 8] <= DWR[8*b +: 8];
      end
    end
  end

  always_comb begin
    rdata = '0;
    if (!oor) rdata = (idx == '0) ? ID_VALUE : regs[idx];
  end

  logic        pv [READ_LATENCY];
  logic [31:0] pd [READ_LATENCY];

  for (genvar g = 0; g < READ_LATENCY; g++) begin : g_pipe
    logic        v_in;
    logic [31:0] d_in;
    if (g == 0) begin : g_first
      assign v_in = rd_acc;
      assign d_in = rdata;
    end else begin : g_next
      assign v_in = pv[g-1];
      assign d_in = pd[g-1];
    end
    // Data stages load only with a valid read, so the last one holds DRD.
    always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
        pv[g] <= 1'b0;
        pd[g] <= '0;
      end else begin
        pv[g] <= v_in;
        if (v_in) pd[g] <= d_in;
      end
    end
  end

  assign DRDY = pv[READ_LATENCY-1];
  assign DRD  = pd[READ_LATENCY-1];

`ifdef MI32_SLAVE_ERRCNT_EN
  logic [15:0] err_q;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      err_q <= '0;
    end else if (ARDY && oor && (err_q != 16'hFFFF)) begin
      err_q <= err_q + 16'd1;
    end
  end

  assign ERR_CNT = err_q;
`else
  assign ERR_CNT = '0;
`endif

endmodule
